config_frame_loader: RTL and testbench

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

---
 rtl/config_frame_loader.sv | 119 +++++++++++
 tb/tb_config_frame_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/config_frame_loader.sv
// Serial configuration frame loader: sof-delimited address + data beats,
// committed one frame at a time into a flat configuration register bank.
module config_frame_loader #(
  parameter int FRAME_BITS = 32,
  parameter int FRAMES     = 4,
  parameter int ADDR_W     = 4
) (
  input  logic                         CLK,
  input  logic                         resetn,
  input  logic                         cfg_valid,
  input  logic                         cfg_bit,
  input  logic                         cfg_sof,
  output logic                         cfg_ready,
  output logic [FRAMES-1:0]            frame_strobe,
  output logic [FRAMES*FRAME_BITS-1:0] cfg_bits,
  output logic                         done,
  output logic                         err
);

  localparam int MAXW  = (ADDR_W > FRAME_BITS) ? ADDR_W : FRAME_BITS;
  localparam int CNT_W = $clog2(MAXW + 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [ADDR_W:0]  N_FR   = (ADDR_W + 1)'(FRAMES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, COMMIT} state_t;

  localparam state_t FIRST = (ADDR_W == 1) ? DATA : ADDR;

  state_t                state_q, state_d;
  logic                  run_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [FRAME_BITS-1:0] shreg_q;

  logic                  accept;
  logic                  start;
  logic                  last_a;
  logic                  last_d;
  logic                  hit;
  logic [ADDR_W-1:0]     addr_nx;
  logic [FRAME_BITS-1:0] data_nx;

  // run_q holds ready low for the first edge after reset release
  assign cfg_ready = run_q && (state_q != COMMIT);
  assign accept    = cfg_valid && cfg_ready;
  assign start     = accept && cfg_sof;
  assign last_a    = (cnt_q == A_LAST);
  assign last_d    = (cnt_q == D_LAST);
  assign hit       = ({1'b0, addr_q} < N_FR);
  assign addr_nx   = (addr_q << 1) | ADDR_W'(cfg_bit);
  assign data_nx   = (shreg_q << 1) | FRAME_BITS'(cfg_bit);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_strobe = '0;
    done         = 1'b0;
    err          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FIRST;
      end
      ADDR: begin
        if (start)       state_d = FIRST;
        else if (accept && last_a) state_d = DATA;
      end
      DATA: begin
        if (start)       state_d = FIRST;
        else if (accept && last_d) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (hit) begin
          frame_strobe = FRAMES'(1) << addr_q;
          done         = 1'b1;
        end else begin
          err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      shreg_q  <= '0;
      cfg_bits <= '0;
    end else begin
      if (start) begin
        cnt_q   <= (ADDR_W == 1) ? '0 : CNT_W'(1);
        addr_q  <= ADDR_W'(cfg_bit);
        shreg_q <= '0;
      end else if (accept && state_q == ADDR) begin
        cnt_q  <= last_a ? '0 : cnt_q + CNT_W'(1);
        addr_q <= addr_nx;
      end else if (accept && state_q == DATA) begin
        cnt_q   <= last_d ? '0 : cnt_q + CNT_W'(1);
        shreg_q <= data_nx;
      end
      for (int f = 0; f < FRAMES; f++) begin
        if (frame_strobe[f])
          cfg_bits[f*FRAME_BITS +: FRAME_BITS] <= shreg_q;
      end
    end
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// Randomized bench for config_frame_loader with a frame-level reference
// model plus directed literal checks of the documented scenarios.
module tb_config_frame_loader;

  localparam int FB = 8;
  localparam int FR = 4;
  localparam int AW = 4;
  localparam int NB = AW + FB;

  logic          CLK = 1'b0;
  logic          resetn;
  logic          cfg_valid;
  logic          cfg_bit;
  logic          cfg_sof;
  logic          cfg_ready;
  logic [FR-1:0] frame_strobe;
  logic [FR*FB-1:0] cfg_bits;
  logic          done;
  logic          err;

  config_frame_loader #(
    .FRAME_BITS(FB),
    .FRAMES    (FR),
    .ADDR_W    (AW)
  ) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .cfg_valid   (cfg_valid),
    .cfg_bit     (cfg_bit),
    .cfg_sof     (cfg_sof),
    .cfg_ready   (cfg_ready),
    .frame_strobe(frame_strobe),
    .cfg_bits    (cfg_bits),
    .done        (done),
    .err         (err)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errs    = 0;
  bit cmp_on  = 1'b0;
  int gmode   = 0;
  bit tgl     = 1'b0;

  // frame-level model: counts beats since sof, commits after NB of them
  bit          m_run;
  bit          m_pend;
  bit          m_coll;
  bit          m_acc_ok;
  int          m_n;
  logic [NB-1:0] m_acc;
  logic [AW-1:0] m_paddr;
  logic [FB-1:0] m_pdata;
  logic [FB-1:0] m_frames [FR];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_pend = 0; m_coll = 0; m_acc_ok = 0; m_n = 0;
    m_acc = '0; m_paddr = '0; m_pdata = '0;
    for (int f = 0; f < FR; f++) m_frames[f] = '0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge CLK or negedge resetn);
      if (!resetn) begin
        model_clear();
      end else begin
        m_acc_ok = m_run && !m_pend && cfg_valid;
        if (m_pend) begin
          if (int'(m_paddr) < FR) m_frames[m_paddr] = m_pdata;
          m_pend = 0;
        end
        if (m_acc_ok) begin
          if (cfg_sof) begin
            m_coll = 1; m_n = 1; m_acc = '0; m_acc[0] = cfg_bit;
          end else if (m_coll) begin
            m_acc = {m_acc[NB-2:0], cfg_bit};
            m_n++;
          end
          if (m_coll && m_n == NB) begin
            m_pend  = 1;
            m_paddr = m_acc[NB-1:FB];
            m_pdata = m_acc[FB-1:0];
            m_coll  = 0;
          end
        end
        m_run = 1;
      end
    end
  end

  initial begin
    logic [FR*FB-1:0] eb;
    logic [FR-1:0]    es;
    forever begin
      @(negedge CLK);
      if (cmp_on) begin
        for (int f = 0; f < FR; f++) eb[f*FB +: FB] = m_frames[f];
        es = (m_pend && int'(m_paddr) < FR) ? (FR'(1) << m_paddr) : '0;
        chk("cfg_ready", 64'(cfg_ready), 64'(m_run && !m_pend));
        chk("frame_strobe", 64'(frame_strobe), 64'(es));
        chk("done", 64'(done), 64'(m_pend && int'(m_paddr) < FR));
        chk("err", 64'(err), 64'(m_pend && int'(m_paddr) >= FR));
        chk("cfg_bits", 64'(cfg_bits), 64'(eb));
      end
    end
  end

  function automatic bit want_gap();
    if (gmode == 1) begin
      tgl = ~tgl;
      return tgl;
    end
    if (gmode == 2) return ($urandom % 4) == 0;
    return 1'b0;
  endfunction

  task automatic beat(input logic s, input logic b);
    int guard = 0;
    bit got   = 0;
    while (!got) begin
      @(negedge CLK);
      if (want_gap()) begin
        cfg_valid = 1'b0;
        cfg_sof   = 1'($urandom);
        cfg_bit   = 1'($urandom);
        @(posedge CLK);
      end else begin
        cfg_valid = 1'b1;
        cfg_sof   = s;
        cfg_bit   = b;
        @(posedge CLK);
        #1 got = m_acc_ok;
      end
      guard++;
      if (!got && guard > 40) begin
        chk("beat_timeout", 64'(got), 64'(1));
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [AW-1:0] a, input logic [FB-1:0] d,
                            input int nd);
    beat(1'b1, a[AW-1]);
    for (int i = AW - 2; i >= 0; i--) beat(1'b0, a[i]);
    for (int i = FB - 1; i >= FB - nd; i--) beat(1'b0, d[i]);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 resetn = 1'b0;
    cfg_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_cfg_bits", 64'(cfg_bits), 64'h0);
    chk("rst_ready", 64'(cfg_ready), 64'h0);
    chk("rst_pulses", 64'({frame_strobe, done, err}), 64'h0);
    #2 resetn = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", 64'(cfg_ready), 64'h1);
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    resetn = 1'b0; cfg_valid = 1'b0; cfg_sof = 1'b0; cfg_bit = 1'b0;
    repeat (2) @(posedge CLK);
    #1 cmp_on = 1'b1;
    do_reset();

    gmode = 0;
    send_frame(4'h2, 8'hA5, FB);
    idle_cycle();
    chk("a5_strobe", 64'(frame_strobe), 64'b0100);
    chk("a5_done", 64'(done), 64'h1);
    chk("a5_ready", 64'(cfg_ready), 64'h0);
    @(negedge CLK);
    chk("a5_bits", 64'(cfg_bits), 64'h00A50000);

    send_frame(4'h7, 8'hFF, FB);
    idle_cycle();
    chk("oor_err", 64'(err), 64'h1);
    chk("oor_done", 64'(done), 64'h0);
    chk("oor_strobe", 64'(frame_strobe), 64'h0);
    @(negedge CLK);
    chk("oor_bits", 64'(cfg_bits), 64'h00A50000);

    do_reset();
    send_frame(4'h1, 8'hE0, 3);
    send_frame(4'h0, 8'h3C, FB);
    repeat (2) idle_cycle();
    chk("restart_bits", 64'(cfg_bits), 64'h0000003C);

    gmode = 1;
    send_frame(4'h3, 8'h81, FB);
    repeat (4) idle_cycle();
    chk("gap_bits", 64'(cfg_bits), 64'h8100003C);
    gmode = 0;

    send_frame(4'h1, 8'hC3, 6);
    do_reset();
    chk("midrst_bits", 64'(cfg_bits), 64'h0);
    send_frame(4'h2, 8'h5A, FB);
    repeat (2) idle_cycle();
    chk("after_rst_bits", 64'(cfg_bits), 64'h005A0000);

    for (int it = 0; it < 300; it++) begin
      gmode = ($urandom % 2 == 0) ? 0 : 2;
      r = int'($urandom % 20);
      if (r < 2) begin
        beat(1'b0, 1'($urandom));
      end else if (r < 4) begin
        send_frame(AW'($urandom), FB'($urandom), int'($urandom % FB));
      end else if (r == 4 && it % 5 == 0) begin
        do_reset();
      end else begin
        send_frame(AW'($urandom % 6), FB'($urandom), FB);
      end
      if ($urandom % 3 == 0) idle_cycle();
    end
    repeat (3) idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
